// File: rtl/curl_pkg.sv
// Shared constants and FSM encoding for the curl MWM checker.
// Optional feature macro: CURL_MWM_INVALID_TRIT_EN (adds invalid-trit error reporting).
package curl_pkg;

  localparam int TRITS_PER_WORD = 27;
  localparam int HASH_WORDS     = 9;
  localparam int HASH_TRITS     = 243;
  localparam int CNT_W          = 8;
  localparam int LZ_W           = $clog2(TRITS_PER_WORD + 1);

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_INV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    EVAL
  } state_t;

endpackage

// File: rtl/curl_trit_lz_count.sv
// Counts consecutive zero trits of one curl word from the top trit downward.
// With CURL_MWM_INVALID_TRIT_EN, also flags an invalid terminating trit.
module curl_trit_lz_count
  import curl_pkg::*;
(
  input  logic [2*TRITS_PER_WORD-1:0] word,
  output logic [LZ_W-1:0]             lz
`ifdef CURL_MWM_INVALID_TRIT_EN
  ,
  output logic                        inv_seen
`endif
);

  logic [TRITS_PER_WORD-1:0] is_zero;
  logic                      scan_run;

  generate
    for (genvar gi = 0; gi < TRITS_PER_WORD; gi++) begin : g_trit
      assign is_zero[gi] = (word[2*gi +: 2] == TRIT_ZERO);
    end
  endgenerate

  // Only the run of zeros and the trit that ends it are examined.
  always_comb begin
    lz       = '0;
    scan_run = 1'b1;
`ifdef CURL_MWM_INVALID_TRIT_EN
    inv_seen = 1'b0;
`endif
    for (int k = TRITS_PER_WORD - 1; k >= 0; k--) begin
      if (scan_run) begin
        if (is_zero[k]) begin
          lz = lz + LZ_W'(1);
        end else begin
          scan_run = 1'b0;
`ifdef CURL_MWM_INVALID_TRIT_EN
          inv_seen = (word[2*k +: 2] == TRIT_INV);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/curl_mwm_checker.sv
// Reads the curl hash top word first, counts trailing zero trits and compares to MWM.
// Optional feature macro: CURL_MWM_INVALID_TRIT_EN (adds o_err output).
module curl_mwm_checker
  import curl_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_start,
  input  logic [CNT_W-1:0]            i_mwm,
  output logic [3:0]                  o_addr,
  input  logic [2*TRITS_PER_WORD-1:0] i_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic [CNT_W-1:0]            o_zero_cnt
`ifdef CURL_MWM_INVALID_TRIT_EN
  ,
  output logic                        o_err
`endif
);

  state_t           state, state_next;
  logic [CNT_W-1:0] mwm_ff;
  logic [LZ_W-1:0]  lz;
  logic [CNT_W-1:0] cnt_sum;
  logic             word_all_zero;
  logic             last_word;
`ifdef CURL_MWM_INVALID_TRIT_EN
  logic             inv_seen;
`endif

  curl_trit_lz_count u_lz (
    .word     (i_data),
    .lz       (lz)
`ifdef CURL_MWM_INVALID_TRIT_EN
    ,
    .inv_seen (inv_seen)
`endif
  );

  assign cnt_sum       = o_zero_cnt + CNT_W'(lz);
  assign word_all_zero = (lz == LZ_W'(TRITS_PER_WORD));
  assign last_word     = (o_addr == '0);
  assign o_busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = ADDR;
      ADDR:    state_next = EVAL;
      EVAL:    state_next = (word_all_zero && !last_word) ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_addr     <= '0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_zero_cnt <= '0;
      mwm_ff     <= '0;
`ifdef CURL_MWM_INVALID_TRIT_EN
      o_err      <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            mwm_ff     <= i_mwm;
            o_addr     <= 4'(HASH_WORDS - 1);
            o_zero_cnt <= '0;
            o_pass     <= 1'b0;
`ifdef CURL_MWM_INVALID_TRIT_EN
            o_err      <= 1'b0;
`endif
          end
        end
        EVAL: begin
          o_zero_cnt <= cnt_sum;
          if (word_all_zero && !last_word) begin
            o_addr <= o_addr - 4'd1;
          end else begin
            o_pass <= (cnt_sum >= mwm_ff);
            o_done <= 1'b1;
          end
`ifdef CURL_MWM_INVALID_TRIT_EN
          o_err <= o_err | inv_seen;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_curl_mwm_checker.sv
// Randomized and directed bench for curl_mwm_checker against a trit-array reference model.
// Exercises o_err when CURL_MWM_INVALID_TRIT_EN is defined.
module tb_curl_mwm_checker;
  import curl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_mwm = '0;
  logic [3:0]  o_addr;
  logic [53:0] i_data = '0;
  logic        o_busy, o_done, o_pass;
  logic [7:0]  o_zero_cnt;
`ifdef CURL_MWM_INVALID_TRIT_EN
  logic        o_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [53:0] mem [0:15];
  int          hash [243];

  curl_mwm_checker dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_start    (i_start),
    .i_mwm      (i_mwm),
    .o_addr     (o_addr),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass     (o_pass),
    .o_zero_cnt (o_zero_cnt)
`ifdef CURL_MWM_INVALID_TRIT_EN
    ,
    .o_err      (o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Curl state memory with one cycle read latency
  always @(posedge i_clk) i_data <= mem[o_addr];

  function automatic void clear_hash();
    for (int k = 0; k < 243; k++) hash[k] = 0;
  endfunction

  function automatic void load_hash();
    for (int w = 0; w < 16; w++) mem[w] = '0;
    for (int k = 0; k < 243; k++) mem[k / 27][2 * (k % 27) +: 2] = 2'(hash[k]);
  endfunction

  // Reference: trailing zero trits from trit 242 down; invalid only if it ends the run
  function automatic void model(output int cnt, output int words, output bit err);
    cnt = 0;
    err = 1'b0;
    for (int k = 242; k >= 0; k--) begin
      if (hash[k] == 0) cnt++;
      else begin
        err = (hash[k] == 2);
        break;
      end
    end
    words = (cnt == 243) ? 9 : cnt / 27 + 1;
  endfunction

  task automatic run_txn(input int mwm, output int done_edge, output int cnt, output bit pass,
                         output bit err, output bit busy_after, output bit done_next);
    done_edge = -1; cnt = -1; pass = 1'b0; err = 1'b0; busy_after = 1'b1; done_next = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_mwm = 8'(mwm);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        done_edge = k;
        cnt = int'(o_zero_cnt);
        pass = o_pass;
        busy_after = o_busy;
`ifdef CURL_MWM_INVALID_TRIT_EN
        err = o_err;
`endif
        @(posedge i_clk);
        #1 done_next = o_done;
        break;
      end
    end
    $display("txn mwm=%0d done_edge=%0d zero_cnt=%0d pass=%0d", mwm, done_edge, cnt, pass);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_pass, o_zero_cnt, o_addr} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b pass=%0b cnt=%0d addr=%0d want all 0",
               o_busy, o_done, o_pass, o_zero_cnt, o_addr);
    end
    @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    int de, c; bit p, e, b, dn;
    clear_hash(); load_hash();
    run_txn(14, de, c, p, e, b, dn);
    checks++;
    if (de !== 18 || c !== 243 || p !== 1'b1) begin
      failures++;
      $display("FAIL all_zero got edge=%0d cnt=%0d pass=%0b want edge=18 cnt=243 pass=1", de, c, p);
    end
    checks++;
    if (b !== 1'b0 || dn !== 1'b0 || o_addr !== 4'd0) begin
      failures++;
      $display("FAIL all_zero_after got busy=%0b done_next=%0b addr=%0d want 0 0 0", b, dn, o_addr);
    end
  endtask

  task automatic test_single_word();
    int de, c; bit p, e, b, dn;
    clear_hash(); hash[242] = 1; load_hash();
    for (int m = 0; m < 2; m++) begin
      run_txn(m, de, c, p, e, b, dn);
      checks++;
      if (de !== 2 || c !== 0 || p !== (m == 0)) begin
        failures++;
        $display("FAIL single_word mwm=%0d got edge=%0d cnt=%0d pass=%0b want edge=2 cnt=0 pass=%0b",
                 m, de, c, p, m == 0);
      end
    end
  endtask

  task automatic test_cross_word();
    int de, c; bit p, e, b, dn;
    clear_hash(); hash[210] = 3; load_hash();
    for (int m = 32; m <= 33; m++) begin
      run_txn(m, de, c, p, e, b, dn);
      checks++;
      if (de !== 4 || c !== 32 || p !== (m == 32)) begin
        failures++;
        $display("FAIL cross_word mwm=%0d got edge=%0d cnt=%0d pass=%0b want edge=4 cnt=32 pass=%0b",
                 m, de, c, p, m == 32);
      end
    end
  endtask

  task automatic test_random();
    int de, c, z, mwm, ec, ew; bit p, e, b, dn, ee;
    for (int t = 0; t < 24; t++) begin
      z = (t == 0) ? 243 : (t == 1) ? 0 : $urandom_range(0, 243);
      for (int k = 0; k < 243; k++) hash[k] = $urandom_range(0, 3);
      for (int k = 242; k > 242 - z; k--) hash[k] = 0;
      if (z < 243) hash[242 - z] = $urandom_range(1, 3);
      load_hash();
      mwm = (t % 4 == 0) ? $urandom_range(244, 255) : $urandom_range(0, 243);
      model(ec, ew, ee);
      run_txn(mwm, de, c, p, e, b, dn);
      checks++;
      if (de !== 2 * ew || c !== ec || p !== (ec >= mwm) || b !== 1'b0) begin
        failures++;
        $display("FAIL random t=%0d mwm=%0d got edge=%0d cnt=%0d pass=%0b busy=%0b want edge=%0d cnt=%0d pass=%0b busy=0",
                 t, mwm, de, c, p, b, 2 * ew, ec, ec >= mwm);
      end
`ifdef CURL_MWM_INVALID_TRIT_EN
      checks++;
      if (e !== ee) begin
        failures++;
        $display("FAIL random_err t=%0d got err=%0b want %0b", t, e, ee);
      end
`endif
    end
  endtask

  task automatic test_busy_ignore();
    int ndone, first_edge; bit p;
    ndone = 0; first_edge = -1; p = 1'b0;
    clear_hash(); load_hash();
    for (int k = 0; k <= 40; k++) begin
      @(negedge i_clk);
      i_start = (k == 0 || k == 3);
      i_mwm = (k == 3) ? 8'd244 : 8'd243;
      @(posedge i_clk);
      #1;
      if (o_done) begin
        ndone++;
        if (first_edge < 0) begin first_edge = k; p = o_pass; end
      end
    end
    i_start = 1'b0;
    $display("txn busy_ignore done_count=%0d done_edge=%0d pass=%0b", ndone, first_edge, p);
    checks++;
    if (ndone !== 1 || first_edge !== 18 || p !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore got dones=%0d edge=%0d pass=%0b want dones=1 edge=18 pass=1",
               ndone, first_edge, p);
    end
  endtask

  task automatic test_start_on_done();
    int ndone; bit busy_seen;
    ndone = 0; busy_seen = 1'b0;
    clear_hash(); hash[242] = 1; load_hash();
    for (int k = 0; k <= 10; k++) begin
      @(negedge i_clk);
      i_start = (k == 0 || k == 2);
      i_mwm = 8'd0;
      @(posedge i_clk);
      #1;
      if (o_done) ndone++;
      if (k >= 2 && o_busy) busy_seen = 1'b1;
    end
    i_start = 1'b0;
    $display("txn start_on_done done_count=%0d busy_after=%0b", ndone, busy_seen);
    checks++;
    if (ndone !== 1 || busy_seen !== 1'b0) begin
      failures++;
      $display("FAIL start_on_done got dones=%0d busy_after=%0b want dones=1 busy_after=0", ndone, busy_seen);
    end
  endtask

  task automatic test_async_reset();
    int de, c; bit p, e, b, dn, any_done;
    any_done = 1'b0;
    clear_hash(); load_hash();
    for (int k = 0; k <= 5; k++) begin
      @(negedge i_clk);
      i_start = (k == 0);
      i_mwm = 8'd7;
      @(posedge i_clk);
    end
    i_start = 1'b0;
    #2 i_arst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_pass, o_zero_cnt, o_addr} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset got busy=%0b done=%0b pass=%0b cnt=%0d addr=%0d want all 0",
               o_busy, o_done, o_pass, o_zero_cnt, o_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk);
      #1 if (o_done || o_busy) any_done = 1'b1;
    end
    @(negedge i_clk);
    i_arst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk);
      #1 if (o_done) any_done = 1'b1;
    end
    checks++;
    if (any_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_nodone got activity=%0b want 0", any_done);
    end
    run_txn(100, de, c, p, e, b, dn);
    checks++;
    if (de !== 18 || c !== 243 || p !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_restart got edge=%0d cnt=%0d pass=%0b want edge=18 cnt=243 pass=1", de, c, p);
    end
  endtask

`ifdef CURL_MWM_INVALID_TRIT_EN
  task automatic test_invalid_trit();
    int de, c; bit p, e, b, dn;
    clear_hash(); hash[240] = 2; load_hash();
    run_txn(0, de, c, p, e, b, dn);
    checks++;
    if (de !== 2 || c !== 2 || e !== 1'b1) begin
      failures++;
      $display("FAIL invalid_trit got edge=%0d cnt=%0d err=%0b want edge=2 cnt=2 err=1", de, c, e);
    end
    hash[240] = 1; load_hash();
    run_txn(0, de, c, p, e, b, dn);
    checks++;
    if (c !== 2 || e !== 1'b0) begin
      failures++;
      $display("FAIL invalid_trit_clear got cnt=%0d err=%0b want cnt=2 err=0", c, e);
    end
  endtask
`endif

  initial begin
    for (int w = 0; w < 16; w++) mem[w] = '0;
    test_reset();
    test_all_zero();
    test_single_word();
    test_cross_word();
    test_random();
    test_busy_ignore();
    test_start_on_done();
    test_async_reset();
`ifdef CURL_MWM_INVALID_TRIT_EN
    test_invalid_trit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
